// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
//   state_t   : sequencer states (idle, start pulse, wait for done)
//   ADC_W     : default sample width per channel
//   OVR_CNT_W : width of the saturating overrun event counter
package adc_sched_pkg;

  localparam int unsigned ADC_W     = 12;
  localparam int unsigned OVR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Increment that sticks at all-ones.
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (v == '1) ? v : v + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-period tick generator.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : run enable; counter held at 0 while low
//   period_i     : period minus 1, loaded on every tick
//   tick_o       : one-cycle pulse, first in the first enabled cycle,
//                  then every period_i+1 cycles
module adc_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= period_i;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  // Internal strobe only; the top registers everything it drives out.
  always_comb begin
    tick_o = en_i && (cnt_q == '0);
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodic / single-shot conversion sequencer for a dual-channel SPI ADC.
//   clk, rst               : clock, asynchronous active-high reset
//   en, trig, period       : continuous enable, single-shot request (en=0 only),
//                            sample period minus 1
//   clr                    : clears overrun, ovr_cnt, timeout
//   adc_start / adc_done   : conversion handshake with the ADC receiver
//   adc_data1 / adc_data2  : converted samples, valid with adc_done
//   smp_ch1/2, smp_valid,
//   smp_ready              : valid/ready sample output register
//   busy                   : sequencer not idle
//   overrun, ovr_cnt       : sticky flag and saturating count of dropped
//                            ticks / overwritten unread samples
//   timeout                : sticky flag, conversion aborted waiting for done
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned ADC_W   = adc_sched_pkg::ADC_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 trig,
  input  logic [DIV_W-1:0]     period,
  input  logic                 clr,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [ADC_W-1:0]     adc_data1,
  input  logic [ADC_W-1:0]     adc_data2,
  output logic [ADC_W-1:0]     smp_ch1,
  output logic [ADC_W-1:0]     smp_ch2,
  output logic                 smp_valid,
  input  logic                 smp_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] ovr_cnt,
  output logic                 timeout
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic tick;

  adc_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .period_i(period),
    .tick_o  (tick)
  );

  state_t                 state_q;
  logic [TO_W-1:0]        wcnt_q;
  logic                   start_q;
  logic                   busy_q;
  logic [ADC_W-1:0]       ch1_q;
  logic [ADC_W-1:0]       ch2_q;
  logic                   valid_q;
  logic                   ovr_q;
  logic [OVR_CNT_W-1:0]   cnt_q;
  logic                   to_q;

  logic capture;
  logic abort;
  logic drop;
  logic overwrite;

  always_comb begin
    capture   = (state_q == ST_WAIT) && adc_done;
    // Abort on the last allowed WAIT cycle so the flag lands TIMEOUT cycles after entry.
    abort     = (state_q == ST_WAIT) && !adc_done && (wcnt_q == TO_W'(TIMEOUT - 1));
    drop      = tick && (state_q != ST_IDLE);
    overwrite = capture && valid_q && !smp_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wcnt_q <= '0;
          if (tick || (trig && !en)) begin
            state_q <= ST_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (capture || abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + TO_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A capture wins over a same-cycle accept: the new sample stays valid.
      if (capture) begin
        ch1_q   <= adc_data1;
        ch2_q   <= adc_data2;
        valid_q <= 1'b1;
      end else if (valid_q && smp_ready) begin
        valid_q <= 1'b0;
      end

      // Drop and overwrite together count as a single event.
      if (clr) begin
        ovr_q <= 1'b0;
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        if (drop || overwrite) begin
          ovr_q <= 1'b1;
          cnt_q <= sat_inc(cnt_q);
        end
        if (abort) begin
          to_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    adc_start = start_q;
    busy      = busy_q;
    smp_ch1   = ch1_q;
    smp_ch2   = ch2_q;
    smp_valid = valid_q;
    overrun   = ovr_q;
    ovr_cnt   = cnt_q;
    timeout   = to_q;
  end

endmodule
